// File: rtl/systolic_skew_feeder.sv
// Input-side skew stage for the systolic array: takes one row vector per handshake
// and emits lane k delayed by k cycles, with per-lane enables and an end-of-stream done pulse.
module systolic_skew_feeder #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    in_last,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES-1:0]        out_en,
  output logic                    done,
  output logic [CNT_W-1:0]        beat_count
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  // The drain counter only needs to reach LANES-2 before handing over to DONE.
  localparam int DC_W = (LANES > 2) ? $clog2(LANES - 1) : 1;
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'((LANES > 1) ? LANES - 2 : 0);
  localparam state_t AFTER_LAST = (LANES == 1) ? DONE : DRAIN;

  state_t          state;
  state_t          state_next;
  logic [DC_W-1:0] drain_cnt;
  logic [DC_W-1:0] drain_cnt_next;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beat_cnt_next;
  logic            accept;

  assign in_ready   = (state == IDLE) || (state == STREAM);
  assign accept     = in_valid && in_ready;
  assign done       = (state == DONE);
  assign beat_count = beat_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
      beat_cnt  <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
      beat_cnt  <= beat_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    beat_cnt_next  = beat_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          beat_cnt_next = CNT_W'(1);
          if (in_last) begin
            state_next     = AFTER_LAST;
            drain_cnt_next = '0;
          end else begin
            state_next = STREAM;
          end
        end
      end
      STREAM: begin
        if (accept) begin
          beat_cnt_next = beat_cnt + 1'b1;
          if (in_last) begin
            state_next     = AFTER_LAST;
            drain_cnt_next = '0;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_next = DONE;
        end else begin
          drain_cnt_next = drain_cnt + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Lane k is a (k+1)-deep delay line; idle cycles inject zero bubbles so gaps are preserved.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DATA_W-1:0] stage_data [0:k];
    logic [k:0]        stage_valid;

    always_ff @(posedge clk) begin
      if (reset) begin
        stage_valid <= '0;
        for (int i = 0; i <= k; i++) begin
          stage_data[i] <= '0;
        end
      end else begin
        stage_valid[0] <= accept;
        stage_data[0]  <= accept ? in_data[k*DATA_W +: DATA_W] : '0;
        for (int i = 1; i <= k; i++) begin
          stage_valid[i] <= stage_valid[i-1];
          stage_data[i]  <= stage_data[i-1];
        end
      end
    end

    assign out_data[k*DATA_W +: DATA_W] = stage_data[k];
    assign out_en[k]                    = stage_valid[k];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: randomized streams compared against a
// timing-level model that records accepted beats per clock edge and derives the skewed view.
module tb_systolic_skew_feeder;

  localparam int DATA_W = 8;
  localparam int LANES  = 4;
  localparam int CNT_W  = 8;
  localparam int DW     = LANES * DATA_W;
  localparam int VW     = 2 + LANES + DW;
  localparam int MAXC   = 4096;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             in_last;
  logic [DW-1:0]    out_data;
  logic [LANES-1:0] out_en;
  logic             done;
  logic [CNT_W-1:0] beat_count;

  int checks = 0;
  int passes = 0;

  // Model state: which edges accepted a beat, what it carried, and when the block is busy.
  int            cyc         = 0;
  int            reset_edge  = 0;
  int            busy_end    = -1;
  int            m_count     = 0;
  bit            m_in_stream = 1'b0;
  bit            hv [MAXC];
  bit            hl [MAXC];
  logic [DW-1:0] hd [MAXC];

  always #5 clk = ~clk;

  systolic_skew_feeder #(
    .DATA_W(DATA_W),
    .LANES (LANES),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_data  (out_data),
    .out_en    (out_en),
    .done      (done),
    .beat_count(beat_count)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      reset_edge  <= cyc + 1;
      busy_end    <= -1;
      m_count     <= 0;
      m_in_stream <= 1'b0;
    end else if (in_valid && (cyc > busy_end)) begin
      hv[cyc+1]   <= 1'b1;
      hd[cyc+1]   <= in_data;
      hl[cyc+1]   <= in_last;
      m_count     <= m_in_stream ? (m_count + 1) % (1 << CNT_W) : 1;
      m_in_stream <= !in_last;
      if (in_last) busy_end <= cyc + LANES;
    end
  end

  // Expected {in_ready, done, out_en, out_data} in the cycle following edge c.
  function automatic logic [VW-1:0] exp_vec(input int c);
    logic [DW-1:0]    d;
    logic [LANES-1:0] en;
    logic             dn;
    int               e;
    d  = '0;
    en = '0;
    dn = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      e = c - k;
      if (e > reset_edge && hv[e]) begin
        d[k*DATA_W +: DATA_W] = hd[e][k*DATA_W +: DATA_W];
        en[k] = 1'b1;
      end
    end
    e = c - LANES + 1;
    if (e > reset_edge && hv[e] && hl[e]) dn = 1'b1;
    return {(c > busy_end), dn, en, d};
  endfunction

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit l, input bit r);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    reset    = r;
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b1, DW'($urandom), 1'b1, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if ({out_en, out_data, done, beat_count} !== '0)
      $display("[TB] FAIL reset_values got=%h required=0", {out_en, out_data, done, beat_count});
    else passes++;
    checks++;
    if ({in_ready, done, out_en, out_data} !== exp_vec(cyc))
      $display("[TB] FAIL reset_vec cyc=%0d got=%h required=%h", cyc, {in_ready, done, out_en, out_data}, exp_vec(cyc));
    else passes++;
  endtask

  task automatic test_single();
    for (int i = 0; i < LANES + 3; i++) begin
      if (i == 0) drive(1'b1, DW'(32'h44332211), 1'b1, 1'b0);
      else        drive(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if ({in_ready, done, out_en, out_data} !== exp_vec(cyc))
        $display("[TB] FAIL single cyc=%0d got=%h required=%h", cyc, {in_ready, done, out_en, out_data}, exp_vec(cyc));
      else passes++;
    end
    checks++;
    if (beat_count !== CNT_W'(1))
      $display("[TB] FAIL single_count got=%0d required=1", beat_count);
    else passes++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < LANES + 5; i++) begin
      if (i < 3) drive(1'b1, DW'($urandom), (i == 2), 1'b0);
      else       drive(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if ({in_ready, done, out_en, out_data} !== exp_vec(cyc))
        $display("[TB] FAIL back_to_back cyc=%0d got=%h required=%h", cyc, {in_ready, done, out_en, out_data}, exp_vec(cyc));
      else passes++;
    end
    checks++;
    if (beat_count !== CNT_W'(3))
      $display("[TB] FAIL b2b_count got=%0d required=3", beat_count);
    else passes++;
  endtask

  task automatic test_gap();
    for (int i = 0; i < LANES + 6; i++) begin
      if (i == 0 || i == 2 || i == 3) drive(1'b1, DW'($urandom), (i == 3), 1'b0);
      else                            drive(1'b0, DW'($urandom), 1'b1, 1'b0);
      checks++;
      if ({in_ready, done, out_en, out_data} !== exp_vec(cyc))
        $display("[TB] FAIL gap cyc=%0d got=%h required=%h", cyc, {in_ready, done, out_en, out_data}, exp_vec(cyc));
      else passes++;
    end
  endtask

  task automatic test_held_valid();
    logic [DW-1:0] q_data [$];
    bit            q_last [$];
    bit            acc;
    for (int i = 0; i < 5; i++) begin
      q_data.push_back(DW'($urandom));
      q_last.push_back(i == 1 || i == 4);
    end
    for (int i = 0; i < 3 * LANES + 8; i++) begin
      acc = 1'b0;
      if (q_data.size() != 0) begin
        acc = (cyc > busy_end);
        drive(1'b1, q_data[0], q_last[0], 1'b0);
      end else begin
        drive(1'b0, '0, 1'b0, 1'b0);
      end
      if (acc) begin
        void'(q_data.pop_front());
        void'(q_last.pop_front());
      end
      checks++;
      if ({in_ready, done, out_en, out_data} !== exp_vec(cyc))
        $display("[TB] FAIL held_valid cyc=%0d got=%h required=%h", cyc, {in_ready, done, out_en, out_data}, exp_vec(cyc));
      else passes++;
    end
    checks++;
    if (beat_count !== CNT_W'(3))
      $display("[TB] FAIL held_count got=%0d required=3", beat_count);
    else passes++;
  endtask

  task automatic test_reset_mid();
    drive(1'b1, DW'($urandom), 1'b0, 1'b0);
    drive(1'b1, DW'($urandom), 1'b0, 1'b0);
    drive(1'b1, DW'($urandom), 1'b1, 1'b1);
    checks++;
    if ({out_en, out_data, done, beat_count} !== '0)
      $display("[TB] FAIL reset_mid_clear got=%h required=0", {out_en, out_data, done, beat_count});
    else passes++;
    for (int i = 0; i < 2 * LANES + 4; i++) begin
      if (i == 1) drive(1'b1, DW'($urandom), 1'b1, 1'b0);
      else        drive(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if ({in_ready, done, out_en, out_data} !== exp_vec(cyc))
        $display("[TB] FAIL reset_mid cyc=%0d got=%h required=%h", cyc, {in_ready, done, out_en, out_data}, exp_vec(cyc));
      else passes++;
    end
    checks++;
    if (beat_count !== CNT_W'(1))
      $display("[TB] FAIL reset_mid_count got=%0d required=1", beat_count);
    else passes++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 257 + LANES + 2; i++) begin
      if (i < 257) drive(1'b1, DW'($urandom), (i == 256), 1'b0);
      else         drive(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if ({in_ready, done, out_en, out_data} !== exp_vec(cyc))
        $display("[TB] FAIL wrap cyc=%0d got=%h required=%h", cyc, {in_ready, done, out_en, out_data}, exp_vec(cyc));
      else passes++;
      if (i == 255) begin
        checks++;
        if (beat_count !== CNT_W'(0))
          $display("[TB] FAIL wrap_zero got=%0d required=0", beat_count);
        else passes++;
      end
    end
    checks++;
    if (beat_count !== CNT_W'(1))
      $display("[TB] FAIL wrap_count got=%0d required=1", beat_count);
    else passes++;
  endtask

  task automatic test_random();
    logic [DW-1:0] q_data [$];
    bit            q_last [$];
    bit            acc;
    int            len;
    for (int s = 0; s < 6; s++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        q_data.push_back(DW'($urandom));
        q_last.push_back(i == len - 1);
      end
    end
    for (int i = 0; i < 200; i++) begin
      acc = 1'b0;
      if (q_data.size() != 0 && $urandom_range(0, 3) != 0) begin
        acc = (cyc > busy_end);
        drive(1'b1, q_data[0], q_last[0], 1'b0);
      end else begin
        drive(1'b0, DW'($urandom), 1'($urandom), 1'b0);
      end
      if (acc) begin
        void'(q_data.pop_front());
        void'(q_last.pop_front());
      end
      checks++;
      if ({in_ready, done, out_en, out_data} !== exp_vec(cyc))
        $display("[TB] FAIL random cyc=%0d got=%h required=%h", cyc, {in_ready, done, out_en, out_data}, exp_vec(cyc));
      else passes++;
      checks++;
      if (beat_count !== CNT_W'(m_count))
        $display("[TB] FAIL random_count cyc=%0d got=%0d required=%0d", cyc, beat_count, m_count);
      else passes++;
    end
  endtask

  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    reset    = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_held_valid();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
